// File: rtl/keypad_encoder.sv
`default_nettype none
// ============================================================================
// Module   : keypad_encoder
// Brief    : Debounced 10-key entry shifting BCD digits into a m:ts time field.
//            Optional macro KEY_PRIORITY_EN resolves multi-key presses to the
//            highest-index key instead of flagging an error.
// Revision : 1.0 - initial release
// ============================================================================
module keypad_encoder #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] keypad,
    input  logic       enable,
    input  logic       clear,
    output logic [3:0] sec,
    output logic [3:0] t,
    output logic [3:0] min,
    output logic       valid,
    output logic       err
);

    localparam logic [7:0] C_CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DEBOUNCE = 2'd1,
        S_HOLD     = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic [9:0] r_pattern;
    logic [9:0] w_pattern_next;
    logic [7:0] r_count;
    logic [7:0] w_count_next;
    logic       w_accept;

    logic       r_pend;
    logic [9:0] r_pend_pat;
    logic [3:0] w_high_idx;
    logic [3:0] w_key_count;
    logic       w_pat_ok;
    logic       w_room;
    logic       w_do_shift;
    logic       w_do_err;

    logic [3:0] r_sec;
    logic [3:0] r_tens;
    logic [3:0] r_min;
    logic       r_valid;
    logic       r_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_pattern <= 10'd0;
            r_count   <= 8'd0;
        end else begin
            r_state   <= w_state_next;
            r_pattern <= w_pattern_next;
            r_count   <= w_count_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_pattern_next = r_pattern;
        w_count_next   = r_count;
        w_accept       = 1'b0;
        if (clear) begin
            w_state_next = S_IDLE;
            w_count_next = 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (keypad != 10'd0 && enable) begin
                        w_pattern_next = keypad;
                        w_count_next   = 8'd0;
                        w_state_next   = S_DEBOUNCE;
                    end
                end
                S_DEBOUNCE: begin
                    if (!enable || keypad == 10'd0) begin
                        w_state_next = S_IDLE;
                        w_count_next = 8'd0;
                    end else if (keypad != r_pattern) begin
                        w_pattern_next = keypad;
                        w_count_next   = 8'd0;
                    end else if (r_count == C_CNT_LAST) begin
                        w_accept     = 1'b1;
                        w_count_next = 8'd0;
                        w_state_next = S_HOLD;
                    end else begin
                        w_count_next = r_count + 8'd1;
                    end
                end
                S_HOLD: begin
                    // Release is tracked even while entry is disabled.
                    if (keypad == 10'd0) begin
                        w_state_next = S_IDLE;
                    end
                end
                default: begin
                    w_state_next = S_IDLE;
                    w_count_next = 8'd0;
                end
            endcase
        end
    end

    // Accepted pattern is staged one cycle so valid/err land D+1 cycles after the press.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pend     <= 1'b0;
            r_pend_pat <= 10'd0;
        end else begin
            r_pend     <= w_accept;
            r_pend_pat <= r_pattern;
        end
    end

    always_comb begin
        w_high_idx  = 4'd0;
        w_key_count = 4'd0;
        for (int k = 0; k < 10; k++) begin
            if (r_pend_pat[k]) begin
                w_high_idx  = 4'(k);
                w_key_count = w_key_count + 4'd1;
            end
        end
    end

`ifdef KEY_PRIORITY_EN
    assign w_pat_ok = (w_key_count != 4'd0);
`else
    assign w_pat_ok = (w_key_count == 4'd1);
`endif

    assign w_room     = (r_sec <= 4'd5);
    assign w_do_shift = r_pend && !clear && w_pat_ok && w_room;
    assign w_do_err   = r_pend && !clear && !(w_pat_ok && w_room);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sec   <= 4'd0;
            r_tens  <= 4'd0;
            r_min   <= 4'd0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_valid <= w_do_shift;
            r_err   <= w_do_err;
            if (clear) begin
                r_sec  <= 4'd0;
                r_tens <= 4'd0;
                r_min  <= 4'd0;
            end else if (w_do_shift) begin
                r_min  <= r_tens;
                r_tens <= r_sec;
                r_sec  <= w_high_idx;
            end
        end
    end

    assign sec   = r_sec;
    assign t     = r_tens;
    assign min   = r_min;
    assign valid = r_valid;
    assign err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_keypad_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_encoder
// Brief    : Directed self-checking bench for keypad_encoder (DEBOUNCE_CYCLES=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_encoder;

    localparam int D = 4;

    logic       clk;
    logic       reset;
    logic [9:0] keypad;
    logic       enable;
    logic       clear;
    logic [3:0] sec;
    logic [3:0] t;
    logic [3:0] min;
    logic       valid;
    logic       err;

    int errors;
    int checks;
    int valid_cnt;
    int err_cnt;
    int both_cnt;

    keypad_encoder #(.DEBOUNCE_CYCLES(D)) dut (
        .clk    (clk),
        .reset  (reset),
        .keypad (keypad),
        .enable (enable),
        .clear  (clear),
        .sec    (sec),
        .t      (t),
        .min    (min),
        .valid  (valid),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (valid) valid_cnt++;
        if (err) err_cnt++;
        if (valid && err) both_cnt++;
    end

    task automatic press(input logic [9:0] pat, input int hold, input int rel);
        keypad = pat;
        repeat (hold) @(negedge clk);
        keypad = 10'd0;
        repeat (rel) @(negedge clk);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; keypad = 10'd0; clear = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({min, t, sec} !== 12'h000) begin
            errors++;
            $display("FAIL reset_regs: got %h expected %h", {min, t, sec}, 12'h000);
        end
        checks++;
        if ({valid, err} !== 2'b00) begin
            errors++;
            $display("FAIL reset_flags: got %b expected %b", {valid, err}, 2'b00);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_sequence();
        int v0, e0;
        v0 = valid_cnt; e0 = err_cnt;
        press(10'd1 << 1, 10, 5);
        checks++;
        if ({min, t, sec} !== 12'h001) begin
            errors++;
            $display("FAIL seq_key1: got %h expected %h", {min, t, sec}, 12'h001);
        end
        press(10'd1 << 4, 10, 5);
        checks++;
        if ({min, t, sec} !== 12'h014) begin
            errors++;
            $display("FAIL seq_key4: got %h expected %h", {min, t, sec}, 12'h014);
        end
        press(10'd1 << 5, 10, 5);
        checks++;
        if ({min, t, sec} !== 12'h145) begin
            errors++;
            $display("FAIL seq_key5: got %h expected %h", {min, t, sec}, 12'h145);
        end
        checks++;
        if (valid_cnt - v0 !== 3 || err_cnt - e0 !== 0) begin
            errors++;
            $display("FAIL seq_pulses: got valid=%0d err=%0d expected valid=3 err=0",
                     valid_cnt - v0, err_cnt - e0);
        end
    endtask

    task automatic test_enable();
        int v0;
        v0 = valid_cnt;
        enable = 1'b0;
        press(10'd1 << 6, 10, 5);
        enable = 1'b1;
        checks++;
        if ({min, t, sec} !== 12'h145 || valid_cnt !== v0) begin
            errors++;
            $display("FAIL enable_low: got regs=%h valid=%0d expected regs=%h valid=0",
                     {min, t, sec}, valid_cnt - v0, 12'h145);
        end
    endtask

    task automatic test_clear();
        do_clear();
        checks++;
        if ({min, t, sec} !== 12'h000) begin
            errors++;
            $display("FAIL clear: got %h expected %h", {min, t, sec}, 12'h000);
        end
    endtask

    task automatic test_shift_boundary();
        int v0;
        v0 = valid_cnt;
        press(10'd1 << 1, 10, 5);
        press(10'd1 << 4, 10, 5);
        press(10'd1 << 5, 10, 5);
        press(10'd1 << 0, 10, 5);
        checks++;
        if ({min, t, sec} !== 12'h450) begin
            errors++;
            $display("FAIL shift_sec5: got %h expected %h", {min, t, sec}, 12'h450);
        end
        checks++;
        if (valid_cnt - v0 !== 4) begin
            errors++;
            $display("FAIL shift_valid: got %0d expected 4", valid_cnt - v0);
        end
    endtask

    task automatic test_err();
        int v0, e0;
        do_clear();
        press(10'd1 << 2, 10, 5);
        press(10'd1 << 7, 10, 5);
        checks++;
        if ({min, t, sec} !== 12'h027) begin
            errors++;
            $display("FAIL err_setup: got %h expected %h", {min, t, sec}, 12'h027);
        end
        v0 = valid_cnt; e0 = err_cnt;
        press(10'd1 << 3, 10, 5);
        checks++;
        if ({min, t, sec} !== 12'h027) begin
            errors++;
            $display("FAIL err_regs: got %h expected %h", {min, t, sec}, 12'h027);
        end
        checks++;
        if (err_cnt - e0 !== 1 || valid_cnt !== v0) begin
            errors++;
            $display("FAIL err_pulse: got err=%0d valid=%0d expected err=1 valid=0",
                     err_cnt - e0, valid_cnt - v0);
        end
    endtask

    task automatic test_bounce();
        int v0;
        do_clear();
        v0 = valid_cnt;
        for (int i = 0; i < 2; i++) begin
            keypad = 10'd1 << 2;
            repeat (2) @(negedge clk);
            keypad = 10'd0;
            repeat (2) @(negedge clk);
        end
        press(10'd1 << 2, 10, 5);
        checks++;
        if (valid_cnt - v0 !== 1 || {min, t, sec} !== 12'h002) begin
            errors++;
            $display("FAIL bounce: got valid=%0d regs=%h expected valid=1 regs=%h",
                     valid_cnt - v0, {min, t, sec}, 12'h002);
        end
    endtask

    task automatic test_multi();
        int v0, e0;
        v0 = valid_cnt; e0 = err_cnt;
        press((10'd1 << 3) | (10'd1 << 8), 10, 5);
`ifdef KEY_PRIORITY_EN
        checks++;
        if ({min, t, sec} !== 12'h028 || valid_cnt - v0 !== 1 || err_cnt !== e0) begin
            errors++;
            $display("FAIL multi_key: got regs=%h valid=%0d err=%0d expected regs=%h valid=1 err=0",
                     {min, t, sec}, valid_cnt - v0, err_cnt - e0, 12'h028);
        end
`else
        checks++;
        if ({min, t, sec} !== 12'h002 || valid_cnt !== v0 || err_cnt - e0 !== 1) begin
            errors++;
            $display("FAIL multi_key: got regs=%h valid=%0d err=%0d expected regs=%h valid=0 err=1",
                     {min, t, sec}, valid_cnt - v0, err_cnt - e0, 12'h002);
        end
`endif
    endtask

    task automatic test_clear_precedence();
        int v0, e0;
        v0 = valid_cnt; e0 = err_cnt;
        keypad = 10'd1 << 6;
        repeat (D) @(negedge clk);
        clear = 1'b1;
        repeat (2) @(negedge clk);
        clear = 1'b0;
        keypad = 10'd0;
        repeat (5) @(negedge clk);
        checks++;
        if ({min, t, sec} !== 12'h000 || valid_cnt !== v0 || err_cnt !== e0) begin
            errors++;
            $display("FAIL clear_precedence: got regs=%h valid=%0d err=%0d expected regs=000 valid=0 err=0",
                     {min, t, sec}, valid_cnt - v0, err_cnt - e0);
        end
    endtask

    task automatic test_reset_async();
        press(10'd1 << 3, 10, 5);
        checks++;
        if ({min, t, sec} !== 12'h003) begin
            errors++;
            $display("FAIL rst_setup: got %h expected %h", {min, t, sec}, 12'h003);
        end
        keypad = 10'd1 << 9;
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({min, t, sec} !== 12'h000 || {valid, err} !== 2'b00) begin
            errors++;
            $display("FAIL rst_async: got regs=%h flags=%b expected regs=000 flags=00",
                     {min, t, sec}, {valid, err});
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 1; i <= D + 2; i++) begin
            @(negedge clk);
            if (i == D + 1) begin
                checks++;
                if (valid !== 1'b0 || sec !== 4'd0) begin
                    errors++;
                    $display("FAIL rst_latency_early: got valid=%b sec=%0d expected valid=0 sec=0",
                             valid, sec);
                end
            end
            if (i == D + 2) begin
                checks++;
                if (valid !== 1'b1 || sec !== 4'd9) begin
                    errors++;
                    $display("FAIL rst_latency: got valid=%b sec=%0d expected valid=1 sec=9",
                             valid, sec);
                end
            end
        end
        keypad = 10'd0;
        repeat (5) @(negedge clk);
    endtask

    initial begin
        errors = 0; checks = 0;
        valid_cnt = 0; err_cnt = 0; both_cnt = 0;
        reset = 1'b1; enable = 1'b1; keypad = 10'd0; clear = 1'b0;
        @(negedge clk);
        test_reset();
        test_sequence();
        test_enable();
        test_clear();
        test_shift_boundary();
        test_err();
        test_bounce();
        test_multi();
        test_clear_precedence();
        test_reset_async();
        checks++;
        if (both_cnt !== 0) begin
            errors++;
            $display("FAIL valid_err_overlap: got %0d expected 0", both_cnt);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no completion expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/keypad_encoder.md
KEYPAD_ENCODER -- requirements
Module: keypad_encoder

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4; consecutive cycles a key pattern SHALL be stable before acceptance (legal range 1..255).
REQ-002 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  reset SHALL be asynchronous and active-high.
REQ-004 keypad  input  10  raw key lines; bit k high = digit key k pressed.
REQ-005 enable  input  1  high = entry allowed; low = keys ignored (oven running).
REQ-006 clear  input  1  synchronous clear of entered time.
REQ-007 sec  output  4  BCD seconds units, 0..9.
REQ-008 t  output  4  BCD seconds tens, 0..5.
REQ-009 min  output  4  BCD minutes, 0..9.
REQ-010 valid  output  1  one-cycle pulse when a digit is shifted in.
REQ-011 err  output  1  one-cycle pulse when an accepted key is rejected.

Function
REQ-012 FSM states SHALL be IDLE, DEBOUNCE, HOLD.
REQ-013 IDLE: keypad nonzero and enable high -> latch pattern, zero counter, go DEBOUNCE; otherwise stay.
REQ-014 DEBOUNCE: pattern equal to latched -> increment counter; pattern changed and nonzero -> relatch, zero counter; pattern zero -> IDLE with no action.
REQ-015 When counter reaches DEBOUNCE_CYCLES-1 with pattern still stable, the key SHALL be accepted and the FSM SHALL go HOLD.
REQ-016 HOLD: stay until keypad == 0 for one cycle, then IDLE; a held key SHALL produce exactly one acceptance.
REQ-017 Accepted one-hot pattern k: if sec <= 5, then min<=t, t<=sec, sec<=k, valid pulses the cycle after acceptance.
REQ-018 Accepted one-hot pattern with sec > 5: registers SHALL be unchanged and err SHALL pulse (tens would exceed 5).
REQ-019 Accepted non-one-hot pattern (two or more keys): behaviour per REQ-026/027.
REQ-020 Previous min value SHALL be discarded on shift (3-digit window).
REQ-021 Latency SHALL be DEBOUNCE_CYCLES+1 cycles from first stable-press edge to valid.
REQ-022 clear high SHALL zero sec, t, min and return FSM to IDLE next cycle; clear SHALL take precedence over a same-cycle acceptance (no valid, no err).
REQ-023 enable falling while in DEBOUNCE SHALL abort to IDLE; enable low in HOLD SHALL not block release detection.
REQ-024 valid and err SHALL never be high simultaneously.

Reset
REQ-025 reset high SHALL immediately force sec=t=min=0, valid=0, err=0, FSM=IDLE, counter=0, independent of clk, including mid-debounce or mid-hold; after release, a still-pressed key SHALL be treated as a new press.

Configuration
REQ-026 Macro KEY_PRIORITY_EN defined: multi-key pattern SHALL resolve to highest-index pressed key and be processed per REQ-017/018.
REQ-027 KEY_PRIORITY_EN undefined: multi-key accepted pattern SHALL pulse err, leave registers unchanged, and go HOLD.

Verification
REQ-028 Reset, press key 1, 4, 5 sequentially (each held 10 cycles, released 5) -> min=1, t=4, sec=5; three valid pulses, no err.
REQ-029 sec=7 stored, press key 3 -> err pulse, sec=7, t/min unchanged.
REQ-030 Key 2 bouncing (toggle every 2 cycles for 8 cycles, then stable 10) with DEBOUNCE_CYCLES=4 -> exactly one valid, sec=2.
REQ-031 Keys 3 and 8 together: without KEY_PRIORITY_EN -> err, registers unchanged; with it -> sec=8, valid.
REQ-032 enable=0, press key 6 -> no valid, no change; clear asserted with sec=5,t=4,min=1 -> all 0 next cycle.
REQ-033 Assert reset during DEBOUNCE of key 9 -> outputs 0 immediately; release reset with key held -> sec=9 after DEBOUNCE_CYCLES+1 cycles.
